// File: rtl/usb_uart_tx_arbiter.sv
// Round-robin arbiter merging byte streams into the usb_uart uart_in port.
// A grant is held until an EOL byte, a full burst, or an idle timeout.
module usb_uart_tx_arbiter #(
  parameter int         NUM_REQ      = 2,
  parameter int         MAX_BURST    = 64,
  parameter int         IDLE_TIMEOUT = 1024,
  parameter logic [7:0] EOL_BYTE     = 8'h0A
) (
  input  logic                 clk_48mhz,
  input  logic                 reset,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_in_data,
  output logic                 uart_in_valid,
  input  logic                 uart_in_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic [7:0]      burst_q, burst_d;
  logic [15:0]     idle_q, idle_d;

  logic            found;
  logic [OW-1:0]   pick;
  int              idx;
  logic            own_valid;
  logic [7:0]      own_data;
  logic            xfer;
  logic [7:0]      burst_inc;
  logic [15:0]     idle_inc;

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
      burst_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
    end
  end

  // Search starts just after the previous owner so everyone gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
  end

  assign own_valid = req_valid[owner_q];
  assign own_data  = req_data[int'(owner_q)*8 +: 8];
  assign xfer      = (state_q == LOCKED) && own_valid && uart_in_ready;
  assign burst_inc = burst_q + 8'd1;
  assign idle_inc  = idle_q + 16'd1;
  assign busy      = (state_q == LOCKED);

  always_comb begin
    req_ready     = '0;
    grant         = '0;
    uart_in_data  = 8'h00;
    uart_in_valid = 1'b0;
    if (state_q == LOCKED) begin
      uart_in_data       = own_data;
      uart_in_valid      = own_valid;
      req_ready[owner_q] = uart_in_ready;
      grant[owner_q]     = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    idle_d  = idle_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOCKED;
          owner_d = pick;
          burst_d = '0;
          idle_d  = '0;
        end
      end
      LOCKED: begin
        if (xfer) begin
          burst_d = burst_inc;
          idle_d  = '0;
          if (own_data == EOL_BYTE ||
              burst_inc == 8'(MAX_BURST)) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end else if (!own_valid) begin
          idle_d = idle_inc;
          if (idle_inc == 16'(IDLE_TIMEOUT)) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/usb_uart_tx_arbiter.md
USB_UART_TX_ARBITER -- requirements
Module: usb_uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of byte-stream requesters (legal 2..4).
REQ-002 Parameter MAX_BURST, default 64, max bytes per grant before forced release (legal 1..255).
REQ-003 Parameter IDLE_TIMEOUT, default 1024, cycles of owner valid-low before forced release (legal 2..65535).
REQ-004 Parameter EOL_BYTE, default 8'h0A, byte whose transfer releases the grant.
REQ-005 clk_48mhz  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req_data  input  NUM_REQ*8  requester i byte on bits [8i+7:8i].
REQ-008 req_valid  input  NUM_REQ  requester i byte valid.
REQ-009 req_ready  output  NUM_REQ  requester i byte accepted.
REQ-010 uart_in_data  output  8  byte toward usb_uart uart_in pipeline.
REQ-011 uart_in_valid  output  1  byte valid toward usb_uart.
REQ-012 uart_in_ready  input  1  usb_uart accepts byte.
REQ-013 grant  output  NUM_REQ  one-hot current owner, all-zero when idle.
REQ-014 busy  output  1  high while state is LOCKED.

Function
REQ-015 Transfer on a port SHALL occur on a rising edge where valid and ready are both high.
REQ-016 States SHALL be IDLE and LOCKED; owner register SHALL be $clog2(NUM_REQ) bits, last_owner likewise.
REQ-017 In IDLE, all req_ready, uart_in_valid, and grant SHALL be 0; uart_in_data SHALL be 8'h00.
REQ-018 In IDLE with any req_valid high, next cycle SHALL be LOCKED with owner = first i with req_valid[i] high, searching from last_owner+1 upward modulo NUM_REQ (round-robin).
REQ-019 In IDLE with no req_valid high, state SHALL remain IDLE.
REQ-020 In LOCKED, uart_in_data = req_data[owner], uart_in_valid = req_valid[owner], req_ready[owner] = uart_in_ready, all other req_ready = 0, combinationally (zero added latency).
REQ-021 burst_cnt SHALL be 8 bits, cleared on entry to LOCKED, incremented on each uart_in transfer.
REQ-022 idle_cnt SHALL be 16 bits, cleared on entry to LOCKED and on each transfer, incremented each LOCKED cycle with req_valid[owner] low, held when valid high and ready low (stall is not idle).
REQ-023 LOCKED SHALL release to IDLE on the edge of a transfer whose byte equals EOL_BYTE.
REQ-024 LOCKED SHALL release to IDLE on the edge of a transfer making burst_cnt equal MAX_BURST.
REQ-025 LOCKED SHALL release to IDLE on the edge where idle_cnt would reach IDLE_TIMEOUT with req_valid[owner] low.
REQ-026 Simultaneous EOL and MAX_BURST on one transfer SHALL cause a single release; no byte SHALL be dropped or duplicated.
REQ-027 On any release, last_owner SHALL be loaded with owner.
REQ-028 Release SHALL never occur while req_valid[owner] is high and uart_in_ready is low.
REQ-029 Minimum gap between a release transfer and the next granted transfer SHALL be 2 cycles (one IDLE cycle, one LOCKED entry).
REQ-030 A requester dropping valid mid-burst SHALL retain ownership until timeout, EOL, or MAX_BURST.

Reset
REQ-031 On reset assertion, state SHALL become IDLE immediately, and all outputs SHALL take IDLE values (REQ-017) without waiting for a clock edge.
REQ-032 Reset SHALL set last_owner to NUM_REQ-1 (requester 0 wins first), burst_cnt and idle_cnt to 0.
REQ-033 Reset mid-burst SHALL abandon the burst; first arbitration after reset deassertion follows REQ-018.

Verification
REQ-034 Req0 sends "AB\n" with ready=1 -> grant=01 one cycle after valid, three transfers, IDLE on the cycle after 8'h0A, grant=00.
REQ-035 Req0 and req1 both valid continuously, no EOL, MAX_BURST=4 -> owner order 0,1,0,1, exactly 4 bytes each, 2-cycle gap between bursts.
REQ-036 Req1 owner, sends 1 byte then valid low, IDLE_TIMEOUT=8 -> release after 8 idle cycles; req0 granted next.
REQ-037 Owner valid high, uart_in_ready low 2000 cycles -> no release, data stable, idle_cnt=0; transfer occurs when ready rises.
REQ-038 Reset asserted mid-burst on a non-edge -> grant, busy, req_ready, uart_in_valid go 0 immediately; after release, req0 wins a tie.
REQ-039 Byte equal to EOL_BYTE as 4th byte with MAX_BURST=4 -> single release, 4 bytes delivered, no duplicate.
